// File: rtl/register_file.sv
// register_file
// -----------------------------------------------------------------------------
// General-purpose register file for the ID stage of the pipelined CPU.
// Provides two combinational read ports and one synchronous write port.
// Register $0 is hardwired to zero and has no storage behind it.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a same-cycle write is forwarded to any read port addressing
//                the register being written (write-first / read-second).
//   undefined -> read ports return stored contents only.
//
// Parameters:
//   DATA_WIDTH  width of each register and of the data ports (default 32)
//   ADDR_WIDTH  register index width; 2**ADDR_WIDTH registers (default 5)
//
// Ports:
//   clk          rising-edge clock for all writes
//   reset        asynchronous active-low reset, clears every register
//   RegWrite     write enable, sampled at the rising edge of clk
//   write_addr   destination register index
//   write_data   value to write
//   read_addr_1  read port 1 index
//   read_addr_2  read port 2 index
//   read_data_1  combinational contents of read_addr_1
//   read_data_2  combinational contents of read_addr_2
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Read-side view of every register; entry 0 is a constant zero.
  logic [DATA_WIDTH-1:0] stored [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign stored[gi] = '0;
      end else begin : g_store
        logic [DATA_WIDTH-1:0] value_reg;

        // Address 0 never matches here, so writes to $0 fall away naturally.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            value_reg <= '0;
          end else if (RegWrite && (write_addr == ADDR_WIDTH'(gi))) begin
            value_reg <= write_data;
          end
        end

        assign stored[gi] = value_reg;
      end
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  // Forward only while out of reset so outputs stay zero during reset, and
  // never for $0 so that register always reads zero.
  logic bypass_1;
  logic bypass_2;

  always_comb begin
    bypass_1 = reset && RegWrite && (write_addr == read_addr_1) && (read_addr_1 != '0);
    bypass_2 = reset && RegWrite && (write_addr == read_addr_2) && (read_addr_2 != '0);
  end

  always_comb begin
    read_data_1 = bypass_1 ? write_data : stored[read_addr_1];
    read_data_2 = bypass_2 ? write_data : stored[read_addr_2];
  end
`else
  always_comb begin
    read_data_1 = stored[read_addr_1];
    read_data_2 = stored[read_addr_2];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
// -----------------------------------------------------------------------------
// Directed bench for register_file. Expected values are hand-computed
// constants; where the outcome depends on write-through forwarding the bench
// selects the expectation from the same REGFILE_BYPASS_EN macro.
// -----------------------------------------------------------------------------
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr_1;
  logic [4:0]  read_addr_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  int vectors;
  int errors;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr_1(read_addr_1),
    .read_addr_2(read_addr_2),
    .read_data_1(read_data_1),
    .read_data_2(read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
    $display("vector %0d %s: observed %h expected %h", vectors, tag, observed, expected);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    RegWrite   = 1'b1;
    write_addr = addr;
    write_data = data;
    tick();
    RegWrite   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    errors      = 0;
    reset       = 1'b0;
    RegWrite    = 1'b0;
    write_addr  = '0;
    write_data  = '0;
    read_addr_1 = 5'd0;
    read_addr_2 = 5'd5;
    #3;
    check("reset_rd1_addr0", read_data_1, 32'h0);
    check("reset_rd2_addr5", read_data_2, 32'h0);

    @(negedge clk);
    reset = 1'b1;

    // Reset clears a written register without a clock edge.
    write_reg(5'd5, 32'h1234_5678);
    read_addr_1 = 5'd5;
    read_addr_2 = 5'd5;
    #1;
    check("wr5_rd1", read_data_1, 32'h1234_5678);
    check("wr5_rd2", read_data_2, 32'h1234_5678);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_clr_rd1", read_data_1, 32'h0);
    check("async_clr_rd2", read_data_2, 32'h0);
    read_addr_1 = 5'd0;
    read_addr_2 = 5'd0;
    #1;
    check("async_clr_r0_p1", read_data_1, 32'h0);
    check("async_clr_r0_p2", read_data_2, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Same-cycle write and read of $1.
    @(negedge clk);
    RegWrite    = 1'b1;
    write_addr  = 5'd1;
    write_data  = 32'hAAAA_AAAA;
    read_addr_1 = 5'd1;
    #1;
    check("same_cycle_pre_edge", read_data_1, BYPASS ? 32'hAAAA_AAAA : 32'h0);
    tick();
    check("same_cycle_post_edge", read_data_1, 32'hAAAA_AAAA);
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    check("r1_held", read_data_1, 32'hAAAA_AAAA);

    // Port 2 forwarding while port 1 keeps reading $1.
    @(negedge clk);
    RegWrite    = 1'b1;
    write_addr  = 5'd9;
    write_data  = 32'h5A5A_0F0F;
    read_addr_2 = 5'd9;
    #1;
    check("p2_pre_edge", read_data_2, BYPASS ? 32'h5A5A_0F0F : 32'h0);
    check("p1_unaffected", read_data_1, 32'hAAAA_AAAA);
    tick();
    check("p2_post_edge", read_data_2, 32'h5A5A_0F0F);
    RegWrite = 1'b0;

    // Write to $0 is discarded, including during the write cycle.
    @(negedge clk);
    RegWrite    = 1'b1;
    write_addr  = 5'd0;
    write_data  = 32'hBBBB_BBBB;
    read_addr_2 = 5'd0;
    #1;
    check("r0_during_write", read_data_2, 32'h0);
    tick();
    check("r0_after_write", read_data_2, 32'h0);
    RegWrite = 1'b0;
    #1;
    check("r0_after_drop", read_data_2, 32'h0);

    // Dual-port independence.
    write_reg(5'd3, 32'h0000_0003);
    write_reg(5'd31, 32'hFFFF_FFFF);
    read_addr_1 = 5'd3;
    read_addr_2 = 5'd31;
    #1;
    check("dual_p1_r3", read_data_1, 32'h0000_0003);
    check("dual_p2_r31", read_data_2, 32'hFFFF_FFFF);
    read_addr_1 = 5'd31;
    read_addr_2 = 5'd3;
    #1;
    check("swap_p1_r31", read_data_1, 32'hFFFF_FFFF);
    check("swap_p2_r3", read_data_2, 32'h0000_0003);
    read_addr_1 = 5'd9;
    read_addr_2 = 5'd9;
    #1;
    check("same_addr_p1", read_data_1, 32'h5A5A_0F0F);
    check("same_addr_p2", read_data_2, 32'h5A5A_0F0F);

    // RegWrite low over several edges leaves $3 alone.
    @(negedge clk);
    RegWrite    = 1'b0;
    write_addr  = 5'd3;
    write_data  = 32'hDEAD_BEEF;
    read_addr_1 = 5'd3;
    tick();
    tick();
    tick();
    check("no_write_r3", read_data_1, 32'h0000_0003);

    // Reset held low across an edge with a write pending.
    @(negedge clk);
    RegWrite    = 1'b1;
    write_addr  = 5'd7;
    write_data  = 32'hCAFE_F00D;
    read_addr_1 = 5'd7;
    read_addr_2 = 5'd1;
    reset       = 1'b0;
    #1;
    check("rst_wr_rd7_low", read_data_1, 32'h0);
    tick();
    check("rst_wr_rd7_edge", read_data_1, 32'h0);
    @(negedge clk);
    RegWrite = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_wr_rd7_released", read_data_1, 32'h0);
    check("rst_cleared_r1", read_data_2, 32'h0);

    // Writes resume at the first edge after release.
    write_reg(5'd7, 32'h0000_0077);
    #1;
    check("resume_r7", read_data_1, 32'h0000_0077);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
